systolic_array_controller: RTL and testbench

Sequencer for an N×N systolic array of 8-bit MAC processing elements. Each job runs clear → skewed operand feed → pipeline flush → result drain. The controller drives the array-wide `mode` and clear, and tells the operand fetch logic which lanes are live at each feed step. It labels each row of results as it shifts out of the array's bottom edge. The array itself has no enable or backpressure, so every phase runs for a fixed, pre-computed number of cycles.

---
 rtl/systolic_array_controller_pkg.sv | 21 ++
 rtl/sa_step_counter.sv | 35 +++
 rtl/systolic_array_controller.sv | 161 ++++++++++++++++
 tb/tb_systolic_array_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_controller_pkg.sv
// rtl/systolic_array_controller_pkg.sv - shared state encoding and phase constants
//
// Purpose: job phase enumeration and the fixed FLUSH length, shared by the
//          controller top and any tooling that decodes its state.
// Ports:   none (package).

package systolic_array_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } sa_state_t;

  // Operand register, accumulator register and result register of the last PE.
  localparam int FLUSH_LEN = 3;

endpackage

// File: rtl/sa_step_counter.sv
// rtl/sa_step_counter.sv - loadable down-counter with zero flag for phase lengths
//
// Purpose: holds the remaining cycle count of the current phase. Loading value
//          L makes the phase last L+1 cycles (zero is raised in the last one).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val this edge (takes priority over decrement)
//   load_val  - W-bit reload value
//   zero      - count is zero

module sa_step_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/systolic_array_controller.sv
// rtl/systolic_array_controller.sv - job sequencer for an NxN systolic MAC array
//
// Purpose: runs clear -> skewed feed -> flush -> drain for one job per start.
//          Every output is a flop loaded from the next-state decode, so nothing
//          combinational reaches the outputs from start or k_len.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - job request (only honoured in IDLE)
//   k_len      - reduction length, legal range 1..KMAX
//   busy       - CLEAR through DRAIN
//   done       - one-cycle end-of-job pulse
//   cfg_err    - one-cycle pulse on a start with illegal k_len
//   array_clr  - PE register clear
//   mode       - 0 accumulate / 1 shift results down
//   feed_t     - current feed step (0 outside FEED)
//   lane_valid - per-lane operand-live mask
//   res_valid  - bottom-row c_out holds a result row
//   res_row    - row index of the result on c_out

module systolic_array_controller
  import systolic_array_controller_pkg::*;
#(
  parameter int N    = 4,
  parameter int KMAX = 15,
  parameter int CW   = $clog2(KMAX + 2 * N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(KMAX+1)-1:0]  k_len,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic                       array_clr,
  output logic                       mode,
  output logic [CW-1:0]              feed_t,
  output logic [N-1:0]               lane_valid,
  output logic                       res_valid,
  output logic [$clog2(N)-1:0]       res_row
);

  localparam int KW = $clog2(KMAX + 1);
  localparam int RW = $clog2(N);

  sa_state_t     state, state_n;
  logic [KW-1:0] k_reg, k_reg_n;
  logic [CW-1:0] feed_t_n;
  logic [RW-1:0] res_row_n;
  logic          cnt_load, cnt_zero;
  logic [CW-1:0] cnt_load_val;
  logic          cfg_err_n, legal;
  logic [N-1:0]  lane_valid_n;

  sa_step_counter #(.W(CW)) u_step (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // Compare in 32 bits so the upper bound stays meaningful whatever KMAX is.
  assign legal = (k_len != '0) && (int'(k_len) <= KMAX);

  always_comb begin
    state_n      = state;
    k_reg_n      = k_reg;
    feed_t_n     = feed_t;
    res_row_n    = res_row;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cfg_err_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            k_reg_n = k_len;
            state_n = S_CLEAR;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        // Last lane is live until step (N-1)+k-1, plus N-1 more steps of skew.
        state_n      = S_FEED;
        feed_t_n     = '0;
        cnt_load     = 1'b1;
        cnt_load_val = CW'(k_reg) + CW'(2 * N - 3);
      end
      S_FEED: begin
        if (cnt_zero) begin
          state_n      = S_FLUSH;
          feed_t_n     = '0;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(FLUSH_LEN - 1);
        end else begin
          feed_t_n = feed_t + 1'b1;
        end
      end
      S_FLUSH: begin
        if (cnt_zero) begin
          state_n      = S_DRAIN;
          res_row_n    = RW'(N - 1);
          cnt_load     = 1'b1;
          cnt_load_val = CW'(N - 1);
        end
      end
      S_DRAIN: begin
        // Bottom row leaves the array first.
        if (cnt_zero) begin
          state_n   = S_DONE;
          res_row_n = '0;
        end else begin
          res_row_n = res_row - 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    for (int i = 0; i < N; i++) begin
      lane_valid_n[i] = (state_n == S_FEED) && (int'(feed_t_n) >= i) &&
                        (int'(feed_t_n) < i + int'(k_reg_n));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k_reg      <= '0;
      feed_t     <= '0;
      res_row    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      array_clr  <= 1'b0;
      mode       <= 1'b0;
      lane_valid <= '0;
      res_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      k_reg      <= k_reg_n;
      feed_t     <= feed_t_n;
      res_row    <= res_row_n;
      busy       <= (state_n == S_CLEAR) || (state_n == S_FEED) ||
                    (state_n == S_FLUSH) || (state_n == S_DRAIN);
      done       <= (state_n == S_DONE);
      cfg_err    <= cfg_err_n;
      array_clr  <= (state_n == S_CLEAR);
      mode       <= (state_n == S_DRAIN);
      lane_valid <= lane_valid_n;
      res_valid  <= (state_n == S_DRAIN);
    end
  end

endmodule

// File: tb/tb_systolic_array_controller.sv
// tb/tb_systolic_array_controller.sv - scoreboard bench for systolic_array_controller

module tb_systolic_array_controller;

  localparam int N    = 4;
  localparam int KMAX = 15;
  localparam int CW   = $clog2(KMAX + 2 * N);
  localparam int KW   = $clog2(KMAX + 1);
  localparam int RW   = $clog2(N);

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          clr;
    logic          mode;
    logic          rv;
    logic [N-1:0]  lv;
    logic [CW-1:0] ft;
    logic [RW-1:0] row;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t o;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy, done, cfg_err, array_clr, mode, res_valid;
  logic [CW-1:0] feed_t;
  logic [N-1:0]  lane_valid;
  logic [RW-1:0] res_row;

  int   cyc;
  int   checks;
  int   failures;
  int   free_cyc;
  exp_t sb[$];

  systolic_array_controller #(.N(N), .KMAX(KMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .array_clr  (array_clr),
    .mode       (mode),
    .feed_t     (feed_t),
    .lane_valid (lane_valid),
    .res_valid  (res_valid),
    .res_row    (res_row)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Whole-job timeline for a start accepted while cycle c is on the bus:
  // CLEAR 1, FEED k+2N-2, FLUSH 3, DRAIN N, DONE 1.
  task automatic push_job(input int c, input int k);
    exp_t e;
    int   feed_end, flush_end, drain_end;
    feed_end  = 1 + (k + 2 * N - 2);
    flush_end = feed_end + 3;
    drain_end = flush_end + N;
    for (int r = 1; r <= drain_end + 1; r++) begin
      e.cyc = c + r;
      e.o   = '0;
      if (r == 1) begin
        e.o.busy = 1'b1;
        e.o.clr  = 1'b1;
      end else if (r <= feed_end) begin
        e.o.busy = 1'b1;
        e.o.ft   = CW'(r - 2);
        for (int i = 0; i < N; i++)
          e.o.lv[i] = ((r - 2) >= i) && ((r - 2) < i + k);
      end else if (r <= flush_end) begin
        e.o.busy = 1'b1;
      end else if (r <= drain_end) begin
        e.o.busy = 1'b1;
        e.o.mode = 1'b1;
        e.o.rv   = 1'b1;
        e.o.row  = RW'(N - 1 - (r - flush_end - 1));
      end else begin
        e.o.done = 1'b1;
      end
      sb.push_back(e);
    end
    free_cyc = c + drain_end + 2;
  endtask

  task automatic step(input logic s, input logic [KW-1:0] k, input logic r);
    exp_t e;
    @(negedge clk);
    start = s;
    k_len = k;
    rst   = r;
    if (r) begin
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      free_cyc = cyc + 1;
    end else if (s && cyc >= free_cyc) begin
      if (k == '0 || int'(k) > KMAX) begin
        e.cyc       = cyc + 1;
        e.o         = '0;
        e.o.cfg_err = 1'b1;
        sb.push_back(e);
      end else begin
        push_job(cyc, int'(k));
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever an entry is due or the DUT drives
  // anything non-idle; the first cycles are always checked for reset state.
  outs_t act, ex;
  logic  due;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL stale_entry cyc=%0d entry_cyc=%0d required=%h", cyc, sb[0].cyc, sb[0].o);
        void'(sb.pop_front());
      end
      act = {busy, done, cfg_err, array_clr, mode, res_valid, lane_valid, feed_t, res_row};
      due = (sb.size() > 0) && (sb[0].cyc == cyc);
      if (due || act != '0 || cyc <= 14) begin
        ex = '0;
        if (due) begin
          ex = sb[0].o;
          void'(sb.pop_front());
        end
        checks++;
        if (act !== ex) begin
          failures++;
          $display("FAIL out_vec cyc=%0d actual=%h required=%h", cyc, act, ex);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    free_cyc = 0;
    rst      = 1'b1;
    start    = 1'b0;
    k_len    = '0;

    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);

    // Basic job k=3, then idle past its end.
    step(1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 22; i++) step(1'b0, 4'd3, 1'b0);

    // Illegal lengths: k_len=0, and 16 which truncates to 0 on a 4-bit port.
    step(1'b1, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    step(1'b1, 4'(16), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0);

    // Reset in the second DRAIN cycle, then a clean job.
    step(1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 4'd3, 1'b0);
    step(1'b0, 4'd3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 4'd5, 1'b0);

    // start held high through back-to-back longest jobs.
    for (int i = 0; i < 70; i++) step(1'b1, 4'd15, 1'b0);
    for (int i = 0; i < 35; i++) step(1'b0, 4'd0, 1'b0);

    // Random starts, lengths and occasional resets.
    for (int i = 0; i < 2500; i++)
      step(($urandom % 4) == 0, KW'($urandom % 16), ($urandom % 300) == 0);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0);

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_empty actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
